// File: rtl/hazard_run_ctrl_if.sv
// rtl/hazard_run_ctrl_if.sv - datapath <-> hazard/run controller signal bundle
// StallCnt and its width parameter exist only with HAZ_STALL_CNT_EN.
interface hazard_run_ctrl_if
`ifdef HAZ_STALL_CNT_EN
   #(parameter int STCNT_W = 16)
`endif
   ;
   logic       Start;
   logic       HaltD;
   logic [3:0] ra1D;
   logic [3:0] ra2D;
   logic [3:0] ra1E;
   logic [3:0] ra2E;
   logic [3:0] WA3E;
   logic [3:0] WA3M;
   logic [3:0] WA3W;
   logic       MemtoRegE;
   logic       RegWriteM;
   logic       RegWriteW;
   logic [1:0] ForwardAE;
   logic [1:0] ForwardBE;
   logic       StallF;
   logic       StallD;
   logic       FlushE;
   logic       Busy;
   logic       Done;
`ifdef HAZ_STALL_CNT_EN
   logic [STCNT_W-1:0] StallCnt;
`endif

   modport master (
      output Start, HaltD, ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
      output MemtoRegE, RegWriteM, RegWriteW,
      input  ForwardAE, ForwardBE, StallF, StallD, FlushE, Busy, Done
`ifdef HAZ_STALL_CNT_EN
      , input StallCnt
`endif
   );

   modport slave (
      input  Start, HaltD, ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
      input  MemtoRegE, RegWriteM, RegWriteW,
      output ForwardAE, ForwardBE, StallF, StallD, FlushE, Busy, Done
`ifdef HAZ_STALL_CNT_EN
      , output StallCnt
`endif
   );
endinterface

// File: rtl/hazard_run_ctrl.sv
// rtl/hazard_run_ctrl.sv - forwarding, load-use stall and run/drain FSM for the 5-stage pipeline
// Optional stall statistics counter enabled by defining HAZ_STALL_CNT_EN.
module hazard_run_ctrl #(
   parameter int DRAIN_CYC = 3
`ifdef HAZ_STALL_CNT_EN
   , parameter int STCNT_W = 16
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   hazard_run_ctrl_if.slave hz
);
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] drain_cnt, drain_cnt_nxt;
   logic          ld_stall;

   assign ld_stall = hz.MemtoRegE && ((hz.ra1D == hz.WA3E) || (hz.ra2D == hz.WA3E));

   // MEM stage holds the newer value, so it wins over WB; forced to 00 while in reset
   always_comb begin
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      if (RST) begin
         if (hz.RegWriteM && (hz.WA3M == hz.ra1E))      hz.ForwardAE = 2'b10;
         else if (hz.RegWriteW && (hz.WA3W == hz.ra1E)) hz.ForwardAE = 2'b01;
         if (hz.RegWriteM && (hz.WA3M == hz.ra2E))      hz.ForwardBE = 2'b10;
         else if (hz.RegWriteW && (hz.WA3W == hz.ra2E)) hz.ForwardBE = 2'b01;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      hz.StallF     = 1'b1;
      hz.StallD     = 1'b1;
      hz.FlushE     = 1'b1;
      hz.Busy       = 1'b0;
      hz.Done       = 1'b0;
      case (state)
         IDLE: begin
            if (hz.Start) state_nxt = RUN;
         end
         RUN: begin
            hz.StallF = ld_stall;
            hz.StallD = ld_stall;
            hz.FlushE = ld_stall;
            hz.Busy   = 1'b1;
            // a halt stuck behind a load stays in D until the bubble is inserted
            if (hz.HaltD && !ld_stall) begin
               state_nxt     = DRAIN;
               drain_cnt_nxt = DW'(DRAIN_CYC - 1);
            end
         end
         DRAIN: begin
            hz.Busy = 1'b1;
            if (drain_cnt == '0) state_nxt = DONE;
            else                 drain_cnt_nxt = drain_cnt - 1'b1;
         end
         DONE: begin
            hz.Done = 1'b1;
            if (hz.Start) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef HAZ_STALL_CNT_EN
   logic [STCNT_W-1:0] stall_cnt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         stall_cnt <= '0;
      else if ((state == IDLE || state == DONE) && hz.Start)
         stall_cnt <= '0;
      else if (state == RUN && ld_stall && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign hz.StallCnt = stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_run_ctrl.sv
// tb/tb_hazard_run_ctrl.sv - self-checking bench for hazard_run_ctrl
// Works with or without HAZ_STALL_CNT_EN; uses a 4-bit counter so saturation is reachable.
module tb_hazard_run_ctrl;
   localparam int DRAIN_CYC = 3;
   localparam int SW        = 4;
   localparam int SMAX      = (1 << SW) - 1;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

`ifdef HAZ_STALL_CNT_EN
   hazard_run_ctrl_if #(.STCNT_W(SW)) bus ();
   hazard_run_ctrl #(.DRAIN_CYC(DRAIN_CYC), .STCNT_W(SW)) dut (.CLK(CLK), .RST(RST), .hz(bus));
`else
   hazard_run_ctrl_if bus ();
   hazard_run_ctrl #(.DRAIN_CYC(DRAIN_CYC)) dut (.CLK(CLK), .RST(RST), .hz(bus));
`endif

   // reference model: running flag, remaining drain cycles, done flag, stall tally
   bit m_run;
   bit m_done;
   int m_drain;
   int m_cnt;

   function automatic logic [1:0] fwd_ref(input logic [3:0] ra);
      if (bus.RegWriteM && bus.WA3M == ra) return 2'b10;
      if (bus.RegWriteW && bus.WA3W == ra) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic ld_ref();
      return bus.MemtoRegE && (bus.ra1D == bus.WA3E || bus.ra2D == bus.WA3E);
   endfunction

   task automatic model_reset();
      m_run = 0; m_done = 0; m_drain = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      logic ld;
      if (!RST) return;
      ld = ld_ref();
      if (m_run) begin
         if (ld && m_cnt < SMAX) m_cnt++;
         if (bus.HaltD && !ld) begin m_run = 0; m_drain = DRAIN_CYC; end
      end else if (m_drain > 0) begin
         m_drain--;
         if (m_drain == 0) m_done = 1;
      end else if (bus.Start) begin
         m_run = 1; m_done = 0; m_cnt = 0;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      bus.Start = 0; bus.HaltD = 0;
      bus.ra1D = 0; bus.ra2D = 0; bus.ra1E = 0; bus.ra2E = 0;
      bus.WA3E = 4'hf; bus.WA3M = 4'hf; bus.WA3W = 4'hf;
      bus.MemtoRegE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
   endtask

   task automatic apply_reset();
      RST = 0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge CLK);
      #1 RST = 1;
      #1;
   endtask

   task automatic go_run();
      bus.Start = 1;
      tick();
      bus.Start = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      bus.RegWriteM = 1; bus.WA3M = 5; bus.ra1E = 5; bus.ra2E = 5;
      RST = 1;
      #1 RST = 0;
      model_reset();
      #2;
      n_cmp++; if (bus.ForwardAE !== 2'b00) begin n_err++; $display("FAIL reset_fwda: got %b want 00", bus.ForwardAE); end
      n_cmp++; if (bus.ForwardBE !== 2'b00) begin n_err++; $display("FAIL reset_fwdb: got %b want 00", bus.ForwardBE); end
      n_cmp++; if ({bus.StallF, bus.StallD, bus.FlushE} !== 3'b111) begin n_err++; $display("FAIL reset_stalls: got %b want 111", {bus.StallF, bus.StallD, bus.FlushE}); end
      n_cmp++; if ({bus.Busy, bus.Done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done: got %b want 00", {bus.Busy, bus.Done}); end
`ifdef HAZ_STALL_CNT_EN
      n_cmp++; if (bus.StallCnt !== '0) begin n_err++; $display("FAIL reset_stallcnt: got %0d want 0", bus.StallCnt); end
`endif
      apply_reset();
   endtask

   task automatic test_start();
      apply_reset();
      bus.Start = 1;
      #1;
      n_cmp++; if ({bus.Busy, bus.StallF} !== 2'b01) begin n_err++; $display("FAIL idle_before_start: got %b want 01", {bus.Busy, bus.StallF}); end
      tick();
      bus.Start = 0;
      #1;
      n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", bus.Busy); end
      n_cmp++; if ({bus.StallF, bus.StallD, bus.FlushE} !== 3'b000) begin n_err++; $display("FAIL start_stalls: got %b want 000", {bus.StallF, bus.StallD, bus.FlushE}); end
   endtask

   task automatic test_forwarding();
      apply_reset();
      go_run();
      bus.RegWriteM = 1; bus.WA3M = 5; bus.RegWriteW = 1; bus.WA3W = 5;
      bus.ra1E = 5; bus.ra2E = 5;
      #1;
      n_cmp++; if ({bus.ForwardAE, bus.ForwardBE} !== 4'b1010) begin n_err++; $display("FAIL fwd_mem_prio: got %b want 1010", {bus.ForwardAE, bus.ForwardBE}); end
      bus.RegWriteM = 0;
      #1;
      n_cmp++; if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0101) begin n_err++; $display("FAIL fwd_wb: got %b want 0101", {bus.ForwardAE, bus.ForwardBE}); end
      bus.ra2E = 6; bus.RegWriteM = 1; bus.WA3M = 6; bus.RegWriteW = 0;
      #1;
      n_cmp++; if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0010) begin n_err++; $display("FAIL fwd_mixed: got %b want 0010", {bus.ForwardAE, bus.ForwardBE}); end
   endtask

   task automatic test_load_use();
      apply_reset();
      go_run();
      bus.MemtoRegE = 1; bus.WA3E = 3; bus.ra2D = 3; bus.ra1D = 1;
      #1;
      n_cmp++; if ({bus.StallF, bus.StallD, bus.FlushE, bus.Busy} !== 4'b1111) begin n_err++; $display("FAIL ld_stall: got %b want 1111", {bus.StallF, bus.StallD, bus.FlushE, bus.Busy}); end
      tick();
      bus.MemtoRegE = 0;
      #1;
      n_cmp++; if ({bus.StallF, bus.StallD, bus.FlushE} !== 3'b000) begin n_err++; $display("FAIL ld_release: got %b want 000", {bus.StallF, bus.StallD, bus.FlushE}); end
`ifdef HAZ_STALL_CNT_EN
      n_cmp++; if (bus.StallCnt !== SW'(1)) begin n_err++; $display("FAIL ld_stallcnt: got %0d want 1", bus.StallCnt); end
`endif
      bus.MemtoRegE = 1; bus.WA3E = 7; bus.ra1D = 7; bus.ra2D = 2;
      #1;
      n_cmp++; if (bus.StallF !== 1'b1) begin n_err++; $display("FAIL ld_stall_ra1: got %b want 1", bus.StallF); end
      bus.WA3E = 9;
      #1;
      n_cmp++; if (bus.StallF !== 1'b0) begin n_err++; $display("FAIL ld_nomatch: got %b want 0", bus.StallF); end
      bus.MemtoRegE = 0;
   endtask

   task automatic test_halt_drain();
      apply_reset();
      go_run();
      bus.HaltD = 1;
      tick();
      bus.HaltD = 0;
      bus.Start = 1;
      for (int j = 0; j < DRAIN_CYC; j++) begin
         #1;
         n_cmp++; if ({bus.Busy, bus.StallF, bus.FlushE, bus.Done} !== 4'b1110) begin n_err++; $display("FAIL drain_cyc%0d: got %b want 1110", j, {bus.Busy, bus.StallF, bus.FlushE, bus.Done}); end
         tick();
      end
      bus.Start = 0;
      #1;
      n_cmp++; if ({bus.Busy, bus.Done, bus.StallF} !== 3'b011) begin n_err++; $display("FAIL drain_done: got %b want 011", {bus.Busy, bus.Done, bus.StallF}); end
      go_run();
      #1;
      n_cmp++; if ({bus.Busy, bus.Done, bus.StallF} !== 3'b100) begin n_err++; $display("FAIL done_restart: got %b want 100", {bus.Busy, bus.Done, bus.StallF}); end
   endtask

   task automatic test_halt_behind_load();
      apply_reset();
      go_run();
      bus.HaltD = 1; bus.MemtoRegE = 1; bus.WA3E = 3; bus.ra1D = 3;
      #1;
      n_cmp++; if ({bus.StallF, bus.Busy} !== 2'b11) begin n_err++; $display("FAIL halt_ld_stall: got %b want 11", {bus.StallF, bus.Busy}); end
      tick();
      bus.MemtoRegE = 0;
      #1;
      n_cmp++; if ({bus.StallF, bus.Busy} !== 2'b01) begin n_err++; $display("FAIL halt_waits: got %b want 01", {bus.StallF, bus.Busy}); end
      tick();
      bus.HaltD = 0;
      repeat (DRAIN_CYC - 1) tick();
      n_cmp++; if ({bus.Busy, bus.Done} !== 2'b10) begin n_err++; $display("FAIL halt_ld_late: got %b want 10", {bus.Busy, bus.Done}); end
      tick();
      n_cmp++; if ({bus.Busy, bus.Done} !== 2'b01) begin n_err++; $display("FAIL halt_ld_done: got %b want 01", {bus.Busy, bus.Done}); end
   endtask

   task automatic test_start_halt_idle();
      apply_reset();
      bus.Start = 1; bus.HaltD = 1;
      tick();
      bus.Start = 0; bus.HaltD = 0;
      #1;
      n_cmp++; if ({bus.Busy, bus.StallF} !== 2'b10) begin n_err++; $display("FAIL start_halt_idle: got %b want 10", {bus.Busy, bus.StallF}); end
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      go_run();
      bus.MemtoRegE = 1; bus.WA3E = 3; bus.ra2D = 3;
      tick();
      bus.MemtoRegE = 0; bus.HaltD = 1;
      tick();
      bus.HaltD = 0;
      tick();
      #1;
      n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL mid_drain_busy: got %b want 1", bus.Busy); end
`ifdef HAZ_STALL_CNT_EN
      n_cmp++; if (bus.StallCnt !== SW'(1)) begin n_err++; $display("FAIL mid_drain_cnt: got %0d want 1", bus.StallCnt); end
`endif
      RST = 0;
      model_reset();
      #1;
      n_cmp++; if ({bus.Busy, bus.Done, bus.StallF} !== 3'b001) begin n_err++; $display("FAIL async_reset: got %b want 001", {bus.Busy, bus.Done, bus.StallF}); end
`ifdef HAZ_STALL_CNT_EN
      n_cmp++; if (bus.StallCnt !== '0) begin n_err++; $display("FAIL async_reset_cnt: got %0d want 0", bus.StallCnt); end
`endif
      #2 RST = 1;
      tick();
      n_cmp++; if ({bus.Busy, bus.Done} !== 2'b00) begin n_err++; $display("FAIL reset_stays_idle: got %b want 00", {bus.Busy, bus.Done}); end
   endtask

`ifdef HAZ_STALL_CNT_EN
   task automatic test_stall_saturate();
      apply_reset();
      go_run();
      bus.MemtoRegE = 1; bus.WA3E = 4; bus.ra1D = 4;
      repeat (SMAX + 5) tick();
      bus.MemtoRegE = 0;
      #1;
      n_cmp++; if (bus.StallCnt !== SW'(SMAX)) begin n_err++; $display("FAIL stallcnt_sat: got %0d want %0d", bus.StallCnt, SMAX); end
   endtask
`endif

   task automatic test_random();
      logic       ld;
      logic [1:0] ea, eb;
      logic       es, ebusy;
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         bus.Start     = ($urandom_range(0, 3) == 0);
         bus.HaltD     = ($urandom_range(0, 31) == 0);
         bus.MemtoRegE = ($urandom_range(0, 1) == 0);
         bus.RegWriteM = 1'($urandom_range(0, 1));
         bus.RegWriteW = 1'($urandom_range(0, 1));
         bus.ra1D = 4'($urandom_range(0, 2)); bus.ra2D = 4'($urandom_range(0, 2));
         bus.ra1E = 4'($urandom_range(0, 2)); bus.ra2E = 4'($urandom_range(0, 2));
         bus.WA3E = 4'($urandom_range(0, 2)); bus.WA3M = 4'($urandom_range(0, 2));
         bus.WA3W = 4'($urandom_range(0, 2));
         #1;
         ld    = ld_ref();
         ea    = fwd_ref(bus.ra1E);
         eb    = fwd_ref(bus.ra2E);
         es    = m_run ? ld : 1'b1;
         ebusy = m_run || (m_drain > 0);
         n_cmp++; if (bus.ForwardAE !== ea) begin n_err++; $display("FAIL rnd_fwda @%0d: got %b want %b", i, bus.ForwardAE, ea); end
         n_cmp++; if (bus.ForwardBE !== eb) begin n_err++; $display("FAIL rnd_fwdb @%0d: got %b want %b", i, bus.ForwardBE, eb); end
         n_cmp++; if ({bus.StallF, bus.StallD, bus.FlushE} !== {es, es, es}) begin n_err++; $display("FAIL rnd_stalls @%0d: got %b want %b", i, {bus.StallF, bus.StallD, bus.FlushE}, {es, es, es}); end
         n_cmp++; if (bus.Busy !== ebusy) begin n_err++; $display("FAIL rnd_busy @%0d: got %b want %b", i, bus.Busy, ebusy); end
         n_cmp++; if (bus.Done !== m_done) begin n_err++; $display("FAIL rnd_done @%0d: got %b want %b", i, bus.Done, m_done); end
`ifdef HAZ_STALL_CNT_EN
         n_cmp++; if (bus.StallCnt !== SW'(m_cnt)) begin n_err++; $display("FAIL rnd_stallcnt @%0d: got %0d want %0d", i, bus.StallCnt, m_cnt); end
`endif
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_forwarding();
      test_load_use();
      test_halt_drain();
      test_halt_behind_load();
      test_start_halt_idle();
      test_reset_mid_drain();
`ifdef HAZ_STALL_CNT_EN
      test_stall_saturate();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
